// File: rtl/zap_wb_arbiter.sv
// Two-master Wishbone B3 arbiter for the ZAP core: code port (M0) and data store adapter (M1).
// Grant is held across a whole transaction or incrementing burst, with round-robin tie-breaking.
module zap_wb_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 64
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_m0_wb_cyc,
  input  logic            i_m0_wb_stb,
  input  logic [AW-1:0]   i_m0_wb_adr,
  input  logic [DW-1:0]   i_m0_wb_dat,
  input  logic [DW/8-1:0] i_m0_wb_sel,
  input  logic [2:0]      i_m0_wb_cti,
  input  logic            i_m0_wb_we,
  output logic            o_m0_wb_ack,
  output logic [DW-1:0]   o_m0_wb_dat,
  input  logic            i_m1_wb_cyc,
  input  logic            i_m1_wb_stb,
  input  logic [AW-1:0]   i_m1_wb_adr,
  input  logic [DW-1:0]   i_m1_wb_dat,
  input  logic [DW/8-1:0] i_m1_wb_sel,
  input  logic [2:0]      i_m1_wb_cti,
  input  logic            i_m1_wb_we,
  output logic            o_m1_wb_ack,
  output logic [DW-1:0]   o_m1_wb_dat,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic [AW-1:0]   o_wb_adr,
  output logic [DW-1:0]   o_wb_dat,
  output logic [DW/8-1:0] o_wb_sel,
  output logic [2:0]      o_wb_cti,
  output logic            o_wb_we,
  input  logic [DW-1:0]   i_wb_dat,
  input  logic            i_wb_ack,
  output logic [1:0]      o_grant,
  output logic            o_wdog
);

  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t        state;
  logic          last;
  logic [CW-1:0] cnt;

  logic req0, req1;
  logic end_ack, norm_rel, wd_hit;

  assign req0 = i_m0_wb_cyc & i_m0_wb_stb;
  assign req1 = i_m1_wb_cyc & i_m1_wb_stb;

  // Slave port follows the current owner; everything is zero while idle.
  always_comb begin
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    o_wb_adr = '0;
    o_wb_dat = '0;
    o_wb_sel = '0;
    o_wb_cti = 3'b000;
    o_wb_we  = 1'b0;
    case (state)
      GNT0: begin
        o_wb_cyc = i_m0_wb_cyc;
        o_wb_stb = i_m0_wb_stb;
        o_wb_adr = i_m0_wb_adr;
        o_wb_dat = i_m0_wb_dat;
        o_wb_sel = i_m0_wb_sel;
        o_wb_cti = i_m0_wb_cti;
        o_wb_we  = i_m0_wb_we;
      end
      GNT1: begin
        o_wb_cyc = i_m1_wb_cyc;
        o_wb_stb = i_m1_wb_stb;
        o_wb_adr = i_m1_wb_adr;
        o_wb_dat = i_m1_wb_dat;
        o_wb_sel = i_m1_wb_sel;
        o_wb_cti = i_m1_wb_cti;
        o_wb_we  = i_m1_wb_we;
      end
      default: ;
    endcase
  end

  assign o_m0_wb_ack = (state == GNT0) & i_wb_ack;
  assign o_m1_wb_ack = (state == GNT1) & i_wb_ack;
  assign o_m0_wb_dat = i_wb_dat;
  assign o_m1_wb_dat = i_wb_dat;
  assign o_grant     = {state == GNT1, state == GNT0};

  // A normal release (end ACK or abandon) takes priority over the watchdog.
  assign end_ack  = i_wb_ack & ((o_wb_cti == 3'b000) | (o_wb_cti == 3'b111));
  assign norm_rel = end_ack | ~o_wb_cyc;
  assign wd_hit   = (MAX_HOLD != 0) && (cnt == HOLD_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      last   <= 1'b1;
      cnt    <= '0;
      o_wdog <= 1'b0;
    end else begin
      o_wdog <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req0 && (!req1 || last))
            state <= GNT0;
          else if (req1)
            state <= GNT1;
        end
        default: begin
          if (!wd_hit)
            cnt <= cnt + 1'b1;
          if (norm_rel || wd_hit) begin
            state  <= IDLE;
            last   <= (state == GNT1);
            o_wdog <= ~norm_rel;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Self-checking bench for zap_wb_arbiter: per-scenario tasks plus an ACK-routing scoreboard.
module tb_zap_wb_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic [2:0]  m0_cti, m1_cti;
  logic        o_m0_wb_ack, o_m1_wb_ack;
  logic [31:0] o_m0_wb_dat, o_m1_wb_dat;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic [2:0]  o_wb_cti;
  logic [31:0] wb_rdat;
  logic        wb_ack;
  logic [1:0]  o_grant;
  logic        o_wdog;

  int checks = 0;
  int errors = 0;

  // Each entry: {m1_ack, m0_ack, data} expected when the slave ACK is routed.
  logic [33:0] exp_q[$];

  zap_wb_arbiter #(.AW(32), .DW(32), .MAX_HOLD(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m0_wb_cyc(m0_cyc), .i_m0_wb_stb(m0_stb), .i_m0_wb_adr(m0_adr),
    .i_m0_wb_dat(m0_dat), .i_m0_wb_sel(m0_sel), .i_m0_wb_cti(m0_cti),
    .i_m0_wb_we(m0_we), .o_m0_wb_ack(o_m0_wb_ack), .o_m0_wb_dat(o_m0_wb_dat),
    .i_m1_wb_cyc(m1_cyc), .i_m1_wb_stb(m1_stb), .i_m1_wb_adr(m1_adr),
    .i_m1_wb_dat(m1_dat), .i_m1_wb_sel(m1_sel), .i_m1_wb_cti(m1_cti),
    .i_m1_wb_we(m1_we), .o_m1_wb_ack(o_m1_wb_ack), .o_m1_wb_dat(o_m1_wb_dat),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_adr(o_wb_adr),
    .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_cti(o_wb_cti),
    .o_wb_we(o_wb_we), .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack),
    .o_grant(o_grant), .o_wdog(o_wdog)
  );

  always #5 i_clk = ~i_clk;

  // Scoreboard: every ACK a master sees must match the next expected routing.
  always @(negedge i_clk) begin
    if (!i_reset && (o_m0_wb_ack || o_m1_wb_ack)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected_ack: got m1_ack=%0b m0_ack=%0b, required no ACK", o_m1_wb_ack, o_m0_wb_ack);
      end else begin
        logic [33:0] e, g;
        e = exp_q.pop_front();
        g = {o_m1_wb_ack, o_m0_wb_ack, (o_m1_wb_ack ? o_m1_wb_dat : o_m0_wb_dat)};
        if (g !== e) begin
          errors++;
          $display("[TB] FAIL sb_ack_route: got %h, required %h", g, e);
        end
      end
    end
  end

  task automatic next_cycle;
    @(posedge i_clk);
    #1;
  endtask

  task automatic m0_set(input logic cyc, input logic [31:0] adr, input logic [2:0] cti,
                        input logic we, input logic [31:0] dat);
    m0_cyc = cyc; m0_stb = cyc; m0_adr = adr; m0_cti = cti; m0_we = we; m0_dat = dat; m0_sel = 4'hF;
  endtask

  task automatic m1_set(input logic cyc, input logic [31:0] adr, input logic [2:0] cti,
                        input logic we, input logic [31:0] dat);
    m1_cyc = cyc; m1_stb = cyc; m1_adr = adr; m1_cti = cti; m1_we = we; m1_dat = dat; m1_sel = 4'hF;
  endtask

  task automatic slave(input logic ack, input logic [31:0] dat);
    wb_ack = ack; wb_rdat = dat;
  endtask

  task automatic do_reset;
    i_reset = 1'b1;
    m0_set(0, 0, 0, 0, 0);
    m1_set(0, 0, 0, 0, 0);
    slave(0, 0);
    next_cycle; next_cycle;
    i_reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    slave(1, 32'h5A5A_5A5A);
    @(negedge i_clk);
    checks++;
    if ({o_grant, o_wb_cyc, o_wb_stb, o_wb_we, o_wdog, o_m0_wb_ack, o_m1_wb_ack} !== 8'b0 ||
        o_wb_adr !== 32'h0 || o_wb_dat !== 32'h0 || o_wb_sel !== 4'h0 || o_wb_cti !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got grant=%b cyc=%b adr=%h wdog=%b acks=%b%b, required all 0",
               o_grant, o_wb_cyc, o_wb_adr, o_wdog, o_m1_wb_ack, o_m0_wb_ack);
    end
    next_cycle;
    slave(0, 0);
  endtask

  task automatic test_tie;
    do_reset;
    m0_set(1, 32'h10, 3'b000, 0, 0);
    m1_set(1, 32'h20, 3'b000, 0, 0);
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b00) begin errors++; $display("[TB] FAIL tie_latency: got grant=%b, required 00", o_grant); end
    next_cycle;
    slave(1, 32'h1111_1111); exp_q.push_back({2'b01, 32'h1111_1111});
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b01 || o_wb_adr !== 32'h10) begin
      errors++; $display("[TB] FAIL tie_first_m0: got grant=%b adr=%h, required 01 00000010", o_grant, o_wb_adr);
    end
    next_cycle;
    slave(0, 0); m0_set(0, 0, 0, 0, 0);
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b00) begin errors++; $display("[TB] FAIL tie_idle_gap: got grant=%b, required 00", o_grant); end
    next_cycle;
    slave(1, 32'h2222_2222); exp_q.push_back({2'b10, 32'h2222_2222});
    m0_set(1, 32'h14, 3'b000, 0, 0);
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b10 || o_wb_adr !== 32'h20) begin
      errors++; $display("[TB] FAIL tie_then_m1: got grant=%b adr=%h, required 10 00000020", o_grant, o_wb_adr);
    end
    next_cycle;
    slave(0, 0); m1_set(1, 32'h24, 3'b000, 0, 0);
    next_cycle;
    slave(1, 32'h3333_3333); exp_q.push_back({2'b01, 32'h3333_3333});
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b01 || o_wb_adr !== 32'h14) begin
      errors++; $display("[TB] FAIL tie_second_m0: got grant=%b adr=%h, required 01 00000014", o_grant, o_wb_adr);
    end
    next_cycle;
    slave(0, 0); m0_set(0, 0, 0, 0, 0);
    next_cycle;
    slave(1, 32'h4444_4444); exp_q.push_back({2'b10, 32'h4444_4444});
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b10) begin errors++; $display("[TB] FAIL tie_alternate_m1: got grant=%b, required 10", o_grant); end
    next_cycle;
    slave(0, 0); m1_set(0, 0, 0, 0, 0);
    next_cycle;
  endtask

  task automatic test_single_read;
    m0_set(1, 32'h100, 3'b000, 0, 0);
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b00) begin errors++; $display("[TB] FAIL read_latency: got grant=%b, required 00", o_grant); end
    next_cycle;
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b01 || o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h100 || o_wb_we !== 1'b0) begin
      errors++; $display("[TB] FAIL read_grant: got grant=%b cyc=%b adr=%h, required 01 1 00000100", o_grant, o_wb_cyc, o_wb_adr);
    end
    next_cycle;
    next_cycle;
    slave(1, 32'hDEAD_BEEF); exp_q.push_back({2'b01, 32'hDEAD_BEEF});
    @(negedge i_clk);
    checks++;
    if (o_m0_wb_ack !== 1'b1 || o_m0_wb_dat !== 32'hDEAD_BEEF) begin
      errors++; $display("[TB] FAIL read_ack: got ack=%b dat=%h, required 1 deadbeef", o_m0_wb_ack, o_m0_wb_dat);
    end
    next_cycle;
    slave(0, 0); m0_set(0, 0, 0, 0, 0);
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b00 || o_wb_cyc !== 1'b0) begin
      errors++; $display("[TB] FAIL read_release: got grant=%b cyc=%b, required 00 0", o_grant, o_wb_cyc);
    end
    next_cycle;
  endtask

  task automatic test_burst;
    m1_set(1, 32'h200, 3'b010, 0, 0);
    next_cycle;
    m0_set(1, 32'h400, 3'b000, 0, 0);
    for (int b = 0; b < 4; b++) begin
      m1_set(1, 32'h200 + 32'(4 * b), (b == 3) ? 3'b111 : 3'b010, 0, 0);
      slave(1, 32'hB000_0000 + 32'(b)); exp_q.push_back({2'b10, 32'hB000_0000 + 32'(b)});
      @(negedge i_clk);
      checks++;
      if (o_grant !== 2'b10 || o_wb_adr !== 32'h200 + 32'(4 * b) || o_m0_wb_ack !== 1'b0) begin
        errors++; $display("[TB] FAIL burst_beat%0d: got grant=%b adr=%h m0_ack=%b, required 10 %h 0",
                           b, o_grant, o_wb_adr, o_m0_wb_ack, 32'h200 + 32'(4 * b));
      end
      next_cycle;
    end
    slave(0, 0); m1_set(0, 0, 0, 0, 0);
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b00) begin errors++; $display("[TB] FAIL burst_release: got grant=%b, required 00", o_grant); end
    next_cycle;
    slave(1, 32'h0000_0400); exp_q.push_back({2'b01, 32'h0000_0400});
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b01 || o_wb_adr !== 32'h400) begin
      errors++; $display("[TB] FAIL burst_next_m0: got grant=%b adr=%h, required 01 00000400", o_grant, o_wb_adr);
    end
    next_cycle;
    slave(0, 0); m0_set(0, 0, 0, 0, 0);
    next_cycle;
  endtask

  task automatic test_abandon;
    m1_set(1, 32'h500, 3'b000, 1, 32'hCAFE_F00D);
    next_cycle;
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b10 || o_wb_we !== 1'b1 || o_wb_dat !== 32'hCAFE_F00D || o_wb_sel !== 4'hF) begin
      errors++; $display("[TB] FAIL abandon_write: got grant=%b we=%b dat=%h sel=%h, required 10 1 cafef00d f",
                         o_grant, o_wb_we, o_wb_dat, o_wb_sel);
    end
    next_cycle;
    m1_set(0, 0, 0, 0, 0);
    @(negedge i_clk);
    checks++;
    if (o_wb_cyc !== 1'b0) begin errors++; $display("[TB] FAIL abandon_cyc: got cyc=%b, required 0", o_wb_cyc); end
    next_cycle;
    slave(1, 32'h7777_7777);
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b00 || o_m0_wb_ack !== 1'b0 || o_m1_wb_ack !== 1'b0) begin
      errors++; $display("[TB] FAIL abandon_late_ack: got grant=%b acks=%b%b, required 00 00", o_grant, o_m1_wb_ack, o_m0_wb_ack);
    end
    next_cycle;
    slave(0, 0);
    next_cycle;
  endtask

  task automatic test_watchdog;
    m0_set(1, 32'h600, 3'b000, 0, 0);
    next_cycle;
    m1_set(1, 32'h700, 3'b000, 0, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      checks++;
      if (o_grant !== 2'b01 || o_wdog !== 1'b0) begin
        errors++; $display("[TB] FAIL wdog_hold%0d: got grant=%b wdog=%b, required 01 0", c, o_grant, o_wdog);
      end
      next_cycle;
    end
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b00 || o_wdog !== 1'b1 || o_wb_cyc !== 1'b0) begin
      errors++; $display("[TB] FAIL wdog_pulse: got grant=%b wdog=%b cyc=%b, required 00 1 0", o_grant, o_wdog, o_wb_cyc);
    end
    next_cycle;
    slave(1, 32'h8888_8888); exp_q.push_back({2'b10, 32'h8888_8888});
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b10 || o_wdog !== 1'b0) begin
      errors++; $display("[TB] FAIL wdog_next_m1: got grant=%b wdog=%b, required 10 0", o_grant, o_wdog);
    end
    next_cycle;
    slave(0, 0); m0_set(0, 0, 0, 0, 0); m1_set(0, 0, 0, 0, 0);
    next_cycle;
  endtask

  task automatic test_reset_midburst;
    m0_set(1, 32'h300, 3'b010, 0, 0);
    next_cycle;
    slave(1, 32'hC000_0000); exp_q.push_back({2'b01, 32'hC000_0000});
    next_cycle;
    slave(0, 0); m0_set(1, 32'h304, 3'b010, 0, 0);
    i_reset = 1'b1;
    next_cycle;
    i_reset = 1'b0;
    slave(1, 32'hC000_0001);
    m1_set(1, 32'h800, 3'b000, 0, 0);
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b00 || o_wb_cyc !== 1'b0 || o_wb_adr !== 32'h0 || o_m0_wb_ack !== 1'b0 || o_wdog !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_outputs: got grant=%b cyc=%b adr=%h m0_ack=%b, required 00 0 0 0",
                         o_grant, o_wb_cyc, o_wb_adr, o_m0_wb_ack);
    end
    next_cycle;
    slave(0, 0);
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b01) begin errors++; $display("[TB] FAIL rst_mid_tie_m0: got grant=%b, required 01", o_grant); end
    next_cycle;
    m0_set(1, 32'h304, 3'b111, 0, 0);
    slave(1, 32'hC000_0002); exp_q.push_back({2'b01, 32'hC000_0002});
    next_cycle;
    slave(0, 0); m0_set(0, 0, 0, 0, 0); m1_set(0, 0, 0, 0, 0);
    next_cycle;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_tie;
    test_single_read;
    test_burst;
    test_abandon;
    test_watchdog;
    test_reset_midburst;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_missing_ack: got %0d pending ACKs, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
